// File: rtl/mcp3_arb_pkg.sv
// Shared constants for the mcp3 four-way arbiter: FSM encoding, pointer reset
// value, hold counter width and the rotate helper.
package mcp3_arb_pkg;

  localparam int HOLD_W = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [3:0] PTR_RESET = 4'b0001;

  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/mcp3_arb04_if.sv
// Request/grant bundle between the requesting engines (master) and the
// arbiter (slave).
interface mcp3_arb04_if;

  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;
  logic       arb_error;

  modport master (
    output req, done,
    input  gnt, gnt_valid, timeout, arb_error
  );

  modport slave (
    input  req, done,
    output gnt, gnt_valid, timeout, arb_error
  );

endinterface

// File: rtl/mcp3_ohc04.sv
// 4-bit one-hot check cell: flags an all-zero vector and a vector with more
// than one bit set as separate errors.
module mcp3_ohc04 (
  input  logic [3:0] vec,
  output logic       zero_err,
  output logic       multi_err
);

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    zero_err  = (vec == 4'b0000);
    multi_err = ((vec & (vec - 4'b0001)) != 4'b0000);
  end

endmodule

// File: rtl/mcp3_arb04.sv
// Four-way round-robin arbiter with grant hold, forced release after MAX_HOLD
// cycles and a sticky one-hot integrity error on pointer and grant.
module mcp3_arb04
  import mcp3_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic         clock,
  input  logic         reset,
  mcp3_arb04_if.slave  bus
);

  localparam bit                LIM_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_SAT = {HOLD_W{1'b1}};

  logic [0:0]        state_r;
  logic [3:0]        ptr_r;
  logic [3:0]        gnt_r;
  logic              gnt_valid_r;
  logic              timeout_r;
  logic              arb_error_r;
  logic [HOLD_W-1:0] hold_cnt_r;

  logic [0:0]        state_nxt_s;
  logic [3:0]        ptr_nxt_s;
  logic [3:0]        gnt_nxt_s;
  logic              timeout_nxt_s;
  logic [HOLD_W-1:0] hold_nxt_s;

  logic              done_hit_s;
  logic              withdraw_s;
  logic              limit_s;
  logic              release_s;

  logic              ptr_zero_s;
  logic              ptr_multi_s;
  logic              gnt_zero_s;
  logic              gnt_multi_s;
  logic              err_now_s;

  // First requester found walking ptr, ptr<<<1, ptr<<<2, ptr<<<3.
  function automatic logic [3:0] rr_pick(input logic [3:0] req_v,
                                         input logic [3:0] ptr_v);
    logic [3:0] cand;
    logic [3:0] pick;
    cand = ptr_v;
    pick = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if ((pick == 4'b0000) && ((req_v & cand) != 4'b0000)) begin
        pick = req_v & cand;
      end else begin
        pick = pick;
      end
      cand = rotl1(cand);
    end
    return pick;
  endfunction

  mcp3_ohc04 u_ptr_chk (
    .vec       (ptr_r),
    .zero_err  (ptr_zero_s),
    .multi_err (ptr_multi_s)
  );

  mcp3_ohc04 u_gnt_chk (
    .vec       (gnt_r),
    .zero_err  (gnt_zero_s),
    .multi_err (gnt_multi_s)
  );

  // Release causes, integrity check and next-state selection.
  always_comb begin
    done_hit_s = ((bus.done & gnt_r) != 4'b0000);
    withdraw_s = ((bus.req & gnt_r) == 4'b0000);
    limit_s    = LIM_EN && (hold_cnt_r == HOLD_LIM);
    release_s  = done_hit_s || withdraw_s || limit_s;

    // A zero grant is only an error while gnt_valid claims a grant.
    err_now_s  = ptr_zero_s | ptr_multi_s | gnt_multi_s
               | (gnt_valid_r & gnt_zero_s)
               | (~gnt_valid_r & ~gnt_zero_s);

    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    gnt_nxt_s     = gnt_r;
    hold_nxt_s    = hold_cnt_r;
    timeout_nxt_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.req != 4'b0000) begin
          gnt_nxt_s   = rr_pick(bus.req, ptr_r);
          state_nxt_s = ST_GRANT;
          hold_nxt_s  = '0;
        end else begin
          gnt_nxt_s   = 4'b0000;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          gnt_nxt_s     = 4'b0000;
          state_nxt_s   = ST_IDLE;
          ptr_nxt_s     = rotl1(gnt_r);
          hold_nxt_s    = '0;
          timeout_nxt_s = limit_s && !done_hit_s && !withdraw_s;
        end else if (hold_cnt_r != HOLD_SAT) begin
          hold_nxt_s    = hold_cnt_r + HOLD_ONE;
        end else begin
          hold_nxt_s    = hold_cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = 4'b0000;
        ptr_nxt_s   = PTR_RESET;
        hold_nxt_s  = '0;
      end
    endcase
  end

  // State, grant, pointer and status registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= PTR_RESET;
      gnt_r       <= 4'b0000;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      arb_error_r <= 1'b0;
      hold_cnt_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      gnt_r       <= gnt_nxt_s;
      gnt_valid_r <= (gnt_nxt_s != 4'b0000);
      timeout_r   <= timeout_nxt_s;
      arb_error_r <= arb_error_r | err_now_s;
      hold_cnt_r  <= hold_nxt_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;
  assign bus.arb_error = arb_error_r;

endmodule

// File: tb/tb_mcp3_arb04.sv
// Directed bench for mcp3_arb04: one instance with MAX_HOLD=4 for the main
// scenarios, one with MAX_HOLD=0 to show forced release can be disabled.
module tb_mcp3_arb04;

  logic clock      = 1'b0;
  logic reset      = 1'b1;
  logic tout0_seen = 1'b0;
  int   n_vec      = 0;
  int   n_err      = 0;

  logic [3:0] fair_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  mcp3_arb04_if u_if ();
  mcp3_arb04_if u_if0 ();

  mcp3_arb04 #(.MAX_HOLD(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if)
  );

  mcp3_arb04 #(.MAX_HOLD(0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (u_if0)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (u_if0.timeout) tout0_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  initial begin
    u_if.req   = 4'b0000;
    u_if.done  = 4'b0000;
    u_if0.req  = 4'b0000;
    u_if0.done = 4'b0000;
    tick();
    tick();
    reset = 1'b0;

    chk_vec("rst_gnt",   u_if.gnt,             4'b0000);
    chk_vec("rst_valid", 4'(u_if.gnt_valid),   4'd0);
    chk_vec("rst_tout",  4'(u_if.timeout),     4'd0);
    chk_vec("rst_err",   4'(u_if.arb_error),   4'd0);
    chk_vec("rst_ptr",   dut.ptr_r,            4'b0001);

    // Single request, then release by done.
    u_if.req = 4'b0100;
    tick();
    chk_vec("single_gnt",   u_if.gnt,           4'b0100);
    chk_vec("single_valid", 4'(u_if.gnt_valid), 4'd1);
    u_if.done = 4'b0100;
    tick();
    chk_vec("single_rel",   u_if.gnt,           4'b0000);
    chk_vec("single_rel_v", 4'(u_if.gnt_valid), 4'd0);
    chk_vec("single_tout",  4'(u_if.timeout),   4'd0);
    chk_vec("single_ptr",   dut.ptr_r,          4'b1000);
    u_if.req  = 4'b0000;
    u_if.done = 4'b0000;

    // Round-robin fairness from the reset pointer.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    u_if.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_vec($sformatf("rr_gnt%0d", i), u_if.gnt, fair_seq[i]);
      u_if.done = fair_seq[i];
      tick();
      chk_vec($sformatf("rr_bubble%0d", i), u_if.gnt, 4'b0000);
      u_if.done = 4'b0000;
    end
    u_if.req = 4'b0000;

    // Forced release after 4 cycles of hold, then regrant.
    u_if.req = 4'b0010;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk_vec($sformatf("hold_gnt%0d", i),  u_if.gnt,         4'b0010);
      chk_vec($sformatf("hold_tout%0d", i), 4'(u_if.timeout), 4'd0);
      tick();
    end
    chk_vec("force_gnt",  u_if.gnt,         4'b0000);
    chk_vec("force_tout", 4'(u_if.timeout), 4'd1);
    tick();
    chk_vec("regrant_gnt",  u_if.gnt,         4'b0010);
    chk_vec("regrant_tout", 4'(u_if.timeout), 4'd0);

    // done on the limit cycle: release without timeout.
    tick();
    tick();
    tick();
    chk_vec("lim_gnt", u_if.gnt, 4'b0010);
    u_if.done = 4'b0010;
    tick();
    chk_vec("lim_done_gnt",  u_if.gnt,         4'b0000);
    chk_vec("lim_done_tout", 4'(u_if.timeout), 4'd0);
    u_if.done = 4'b0000;
    u_if.req  = 4'b0000;

    // Foreign done and foreign req changes leave the grant alone.
    u_if.req = 4'b0100;
    tick();
    chk_vec("ign_gnt0", u_if.gnt, 4'b0100);
    u_if.done = 4'b0001;
    u_if.req  = 4'b1101;
    tick();
    chk_vec("ign_gnt1", u_if.gnt, 4'b0100);
    u_if.done = 4'b0000;

    // Granted requester withdraws; next grant follows the rotated pointer.
    u_if.req = 4'b1001;
    tick();
    chk_vec("wd_gnt",  u_if.gnt,         4'b0000);
    chk_vec("wd_tout", 4'(u_if.timeout), 4'd0);
    tick();
    chk_vec("wd_next", u_if.gnt, 4'b1000);

    // Reset while a grant is held.
    reset = 1'b1;
    tick();
    chk_vec("mid_rst_gnt",   u_if.gnt,           4'b0000);
    chk_vec("mid_rst_valid", 4'(u_if.gnt_valid), 4'd0);
    chk_vec("mid_rst_tout",  4'(u_if.timeout),   4'd0);
    chk_vec("mid_rst_ptr",   dut.ptr_r,          4'b0001);
    reset    = 1'b0;
    u_if.req = 4'b0000;
    tick();

    // Corrupt the pointer for one cycle; error must stick until reset.
    force dut.ptr_r = 4'b0011;
    chk_vec("err_pre", 4'(u_if.arb_error), 4'd0);
    tick();
    chk_vec("err_set", 4'(u_if.arb_error), 4'd1);
    release dut.ptr_r;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_vec($sformatf("err_sticky%0d", i), 4'(u_if.arb_error), 4'd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_vec("err_clr",     4'(u_if.arb_error), 4'd0);
    chk_vec("err_clr_ptr", dut.ptr_r,          4'b0001);

    // MAX_HOLD=0: grant held well past counter saturation, never timed out.
    u_if0.req = 4'b0001;
    tick();
    chk_vec("nolim_gnt0", u_if0.gnt, 4'b0001);
    repeat (300) tick();
    chk_vec("nolim_gnt1",  u_if0.gnt,           4'b0001);
    chk_vec("nolim_valid", 4'(u_if0.gnt_valid), 4'd1);
    chk_vec("nolim_tout",  4'(tout0_seen),      4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcp3_arb04.md
# mcp3_arb04

Four-way round-robin arbiter with grant hold and forced release, sharing one downstream resource (command slot, buffer write port) among four requesters. Grants are registered and strictly one-hot or zero. Internal one-hot integrity of the priority pointer and the grant vector is checked every cycle and reported through a sticky error. Sits between the requesting engines and the shared resource in the AFP datapath.

## Interface
- `MAX_HOLD`, 16: maximum consecutive cycles a single grant may be held; legal range 0..255; 0 disables forced release.
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  4  request vector; bit i = requester i.
- `done`  in  4  release strobe; bit i honoured only while requester i holds the grant.
- `gnt`  out  4  registered grant, one-hot or zero.
- `gnt_valid`  out  1  registered; 1 exactly when `gnt` is non-zero.
- `timeout`  out  1  one-cycle pulse; a grant was forcibly released.
- `arb_error`  out  1  sticky integrity error; cleared only by `reset`.

## Operation
- State machine with two states:
  - **IDLE:** `gnt = 0`.
  - **GRANT:** `gnt` is held.
- Priority pointer `ptr[3:0]` is one-hot. Search order is `ptr`, then `ptr` rotated left by 1, 2, 3, with wrap from bit 3 to bit 0.
- **IDLE**
  - If `req != 0`, select the first set bit in search order.
  - Next cycle: `gnt` = that one-hot value, `gnt_valid` = 1, state → GRANT, `hold_cnt` = 0.
  - If `req == 0`, remain in IDLE.
- **GRANT, release conditions.** Release occurs on any of:
  - `done & gnt != 0`;
  - `req & gnt == 0` (requester withdrew);
  - `MAX_HOLD != 0` and `hold_cnt == MAX_HOLD-1`.
- **GRANT, on release:**
  - Next cycle: `gnt` = 0, `gnt_valid` = 0, state → IDLE.
  - `ptr` ← `gnt` rotated left by 1, so the granted requester becomes lowest priority.
- **Timeout pulse:** `timeout` = 1 in that next cycle only if the sole release cause was the hold limit. If `done` or withdrawal coincides with the limit cycle, `timeout` stays 0.
- **GRANT, no release:** `hold_cnt` increments. It is 8 bits wide and saturates at 255.
- **Ignored inputs:**
  - `done` bits for non-granted requesters are ignored in all states.
  - `req` changes of non-granted requesters do not affect the held grant.
- **`arb_error`** is set, and stays set, when any of these holds in a cycle:
  - `ptr` is not one-hot;
  - `gnt_valid` = 1 and `gnt` is not one-hot;
  - `gnt_valid` = 0 and `gnt != 0`.
- **Reset mid-grant:** synchronous reset overrides everything and produces the reset values below on the next edge. No `timeout` pulse is generated.

## Timing
- Reset values:
  - `gnt` = 4'b0000, `gnt_valid` = 0, `timeout` = 0, `arb_error` = 0;
  - `ptr` = 4'b0001, `hold_cnt` = 0, state = IDLE.
- Request-to-grant latency:
  - `req` sampled at edge N;
  - `gnt` visible after edge N+1 (1 cycle).
- Release latency:
  - release cause sampled at edge M;
  - `gnt` = 0 after edge M+1;
  - earliest next grant after edge M+2.
  - One mandatory bubble cycle between grants.
- **Minimum hold:** 1 cycle (`done` asserted in the first GRANT cycle).
- **Maximum hold:** `MAX_HOLD` cycles of `gnt` asserted.
- **Error latency:** `arb_error` registers 1 cycle after the offending state is present.
- No combinational path from any input to any output.

## Structure
- Shared package `mcp3_arb_pkg`:
  - state encoding `IDLE`/`GRANT`;
  - `PTR_RESET` = 4'b0001;
  - hold counter width constant (8).
- Sub-module: two instances of the team's existing 4-bit one-hot check cell `mcp3_ohc04`.
  - One on `ptr`: error output used directly.
  - One on `gnt`: its "zero" error is masked when `gnt_valid` = 0.
- Rotate-and-priority-select is an inline function; no further sub-modules.

## Test plan
- **Reset then single request:** `req` = 4'b0100 → after 1 cycle `gnt` = 4'b0100; `done` = 4'b0100 → `gnt` = 0 next cycle and `ptr` = 4'b1000.
- **Round-robin fairness:** `req` = 4'b1111 held, each grantee pulses `done` in its first grant cycle → grant order 0001, 0010, 0100, 1000, 0001, with one zero cycle between grants.
- **Forced release:** `MAX_HOLD` = 4, `req` = 4'b0010 held, no `done` → `gnt` = 0010 for exactly 4 cycles, then `timeout` pulses 1 cycle with `gnt` = 0, then regrant of 0010.
- **Simultaneous events:**
  - `done` arrives on the limit cycle → release with `timeout` = 0.
  - `done` = 4'b0001 while 4'b0100 is granted → ignored; grant held.
- **Withdrawal and reset:**
  - Granted requester drops `req` → release next cycle.
  - `reset` asserted mid-grant → all outputs and `ptr` return to reset values next edge; no `timeout`.
- **Error injection:** force `ptr` = 4'b0011 for 1 cycle → `arb_error` = 1 on next edge, remaining 1 until `reset`.
